// File: rtl/sti_pkg.sv
// sti_pkg: stimulus word field positions, sequencer states and burst-length decode.
package sti_pkg;
  localparam int LEN_HI = 13;
  localparam int LEN_LO = 12;
  localparam int FILL   = 8;
  localparam int MSB    = 4;
  localparam int LOW    = 0;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_LOAD, S_WAIT_V, S_STREAM, S_DONE
  } state_t;
  function automatic logic [5:0] exp_len(input logic [1:0] len);
    return {1'b0, len, 3'b000} + 6'd8;
  endfunction
endpackage

// File: rtl/sti_burst_monitor.sv
// sti_burst_monitor: after arm, waits for so_valid to rise, counts the burst and
// flags its end, a length mismatch, or a wait/burst timeout.
module sti_burst_monitor #(
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_arm,
  input  logic       i_so_valid,
  input  logic [5:0] i_expected_len,
  output logic       o_burst_done,
  output logic       o_len_mismatch,
  output logic       o_timeout
);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic          r_wait, r_burst;
  logic [TW-1:0] r_tcnt;
  logic [5:0]    r_bit_cnt;
  logic [TW-1:0] w_tnext;
  logic          w_tlim;
  assign w_tnext        = r_tcnt + TW'(1);
  assign w_tlim         = w_tnext >= TW'(TIMEOUT);
  assign o_burst_done   = r_burst & ~i_so_valid;
  assign o_len_mismatch = o_burst_done & (r_bit_cnt != i_expected_len);
  assign o_timeout      = w_tlim & ((r_wait & ~i_so_valid) | (r_burst & i_so_valid));
  // the rising cycle itself is bit 1 and restarts the timeout count for the burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait    <= 1'b0;
      r_burst   <= 1'b0;
      r_tcnt    <= '0;
      r_bit_cnt <= '0;
    end else if (i_arm) begin
      r_wait    <= 1'b1;
      r_burst   <= 1'b0;
      r_tcnt    <= '0;
      r_bit_cnt <= '0;
    end else if (r_wait) begin
      r_wait    <= ~i_so_valid & ~w_tlim;
      r_burst   <= i_so_valid;
      r_tcnt    <= i_so_valid ? TW'(1) : w_tnext;
      r_bit_cnt <= i_so_valid ? 6'd1 : r_bit_cnt;
    end else if (r_burst) begin
      r_burst   <= i_so_valid & ~w_tlim;
      r_tcnt    <= w_tnext;
      r_bit_cnt <= (&r_bit_cnt) ? r_bit_cnt : r_bit_cnt + 6'd1;
    end
  end
endmodule

// File: rtl/sti_pi_sequencer.sv
// sti_pi_sequencer: fetches pattern/stimulus pairs from memory and issues them to
// STI_DAC one load at a time, gating each next word on the so_valid burst.
module sti_pi_sequencer
  import sti_pkg::*;
#(
  parameter int NUM_WORDS = 100,
  parameter int ADDR_W    = 7,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd,
  input  logic [15:0]       i_pat_q,
  input  logic [15:0]       i_sti_q,
  output logic              o_load,
  output logic [15:0]       o_pi_data,
  output logic [1:0]        o_pi_length,
  output logic              o_pi_fill,
  output logic              o_pi_msb,
  output logic              o_pi_low,
  output logic              o_pi_end,
  input  logic              i_so_valid,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_word_cnt,
  output logic              o_len_err,
  output logic              o_timeout_err
);
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_word_cnt;
  logic [15:0]       r_pi_data;
  logic [1:0]        r_pi_length;
  logic              r_pi_fill, r_pi_msb, r_pi_low, r_pi_end, r_len_err, r_timeout_err;
  logic              w_last, w_burst_done, w_len_mismatch, w_timeout;
  assign w_last = r_word_cnt == ADDR_W'(NUM_WORDS - 1);
  sti_burst_monitor #(.TIMEOUT(TIMEOUT)) u_mon (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_arm         (r_state == S_LOAD),
    .i_so_valid    (i_so_valid),
    .i_expected_len(exp_len(r_pi_length)),
    .o_burst_done  (w_burst_done),
    .o_len_mismatch(w_len_mismatch),
    .o_timeout     (w_timeout)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:   w_next = i_start ? S_FETCH : S_IDLE;
      S_FETCH:  w_next = S_LATCH;
      S_LATCH:  w_next = S_LOAD;
      S_LOAD:   w_next = S_WAIT_V;
      S_WAIT_V: w_next = w_timeout ? S_DONE : i_so_valid ? S_STREAM : S_WAIT_V;
      S_STREAM: w_next = w_timeout ? S_DONE : !w_burst_done ? S_STREAM : w_last ? S_DONE : S_FETCH;
      default:  w_next = S_IDLE;
    endcase
  end
  always_comb begin
    o_mem_rd = r_state == S_FETCH;
    o_load   = r_state == S_LOAD;
    o_done   = r_state == S_DONE;
    o_busy   = r_state != S_IDLE && r_state != S_DONE;
  end
  // pi_end is captured with the last word so it is already high during its LOAD cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_cnt    <= '0;
      r_pi_data     <= '0;
      r_pi_length   <= '0;
      r_pi_fill     <= 1'b0;
      r_pi_msb      <= 1'b0;
      r_pi_low      <= 1'b0;
      r_pi_end      <= 1'b0;
      r_len_err     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == S_IDLE && i_start) begin
        r_word_cnt    <= '0;
        r_pi_end      <= 1'b0;
        r_len_err     <= 1'b0;
        r_timeout_err <= 1'b0;
      end
      if (r_state == S_LATCH) begin
        r_pi_data   <= i_pat_q;
        r_pi_length <= i_sti_q[LEN_HI:LEN_LO];
        r_pi_fill   <= i_sti_q[FILL];
        r_pi_msb    <= i_sti_q[MSB];
        r_pi_low    <= i_sti_q[LOW];
        r_pi_end    <= r_pi_end | w_last;
      end
      if (r_state == S_STREAM && w_burst_done) begin
        r_len_err  <= r_len_err | w_len_mismatch;
        r_word_cnt <= w_last ? r_word_cnt : r_word_cnt + ADDR_W'(1);
      end
      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end
  assign o_mem_addr    = r_word_cnt;
  assign o_word_cnt    = r_word_cnt;
  assign o_pi_data     = r_pi_data;
  assign o_pi_length   = r_pi_length;
  assign o_pi_fill     = r_pi_fill;
  assign o_pi_msb      = r_pi_msb;
  assign o_pi_low      = r_pi_low;
  assign o_pi_end      = r_pi_end;
  assign o_len_err     = r_len_err;
  assign o_timeout_err = r_timeout_err;
endmodule

// File: tb/tb_sti_pi_sequencer.sv
// tb_sti_pi_sequencer: randomized runs against a word-level model of loads, burst
// checks, sticky errors and done latency; includes reset abort and ignored inputs.
module tb_sti_pi_sequencer;
  localparam int NW    = 6;
  localparam int AW    = 7;
  localparam int TMO   = 64;
  localparam int LIMIT = NW * (2 * TMO + 30) + 50;
  logic clk = 0, rst_n = 0, start = 0, sv_resp = 0, sv_extra = 0;
  logic so_valid;
  logic [AW-1:0] mem_addr, word_cnt;
  logic mem_rd, load, pi_end, busy, done, len_err, timeout_err, pi_fill, pi_msb, pi_low;
  logic [1:0] pi_length;
  logic [15:0] pat_q = 0, sti_q = 0, pi_data;
  logic [15:0] pat_mem [2**AW];
  logic [15:0] sti_mem [2**AW];
  int dly [NW];
  int blen [NW];
  int n_chk = 0, n_pass = 0, base = 0, resp_cnt = 0, rk, rc;
  logic [AW-1:0] prev_wc;
  logic [2:0] prev_flags;
  assign so_valid = sv_resp | sv_extra;
  always #5 clk = ~clk;
  sti_pi_sequencer #(.NUM_WORDS(NW), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .o_mem_addr(mem_addr), .o_mem_rd(mem_rd),
    .i_pat_q(pat_q), .i_sti_q(sti_q), .o_load(load), .o_pi_data(pi_data),
    .o_pi_length(pi_length), .o_pi_fill(pi_fill), .o_pi_msb(pi_msb), .o_pi_low(pi_low),
    .o_pi_end(pi_end), .i_so_valid(so_valid), .o_busy(busy), .o_done(done),
    .o_word_cnt(word_cnt), .o_len_err(len_err), .o_timeout_err(timeout_err)
  );
  always @(posedge clk) if (mem_rd) begin
    pat_q <= pat_mem[mem_addr];
    sti_q <= sti_mem[mem_addr];
  end
  // STI_DAC stand-in: dly[k] cycles after load k, so_valid high for blen[k] cycles
  initial forever begin
    @(negedge clk);
    if (rst_n && load) begin
      rk = resp_cnt - base;
      resp_cnt++;
      if (rk >= 0 && rk < NW && dly[rk] != 0) begin
        for (rc = 0; rc < dly[rk] && rst_n; rc++) @(negedge clk);
        if (rst_n) begin
          sv_resp = 1;
          for (rc = 0; rc < blen[rk] && rst_n; rc++) @(negedge clk);
          sv_resp = 0;
        end
      end
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  task automatic check_reset_outs(input string tag);
    check({tag, "_pi"}, {pi_data, pi_length, pi_fill, pi_msb, pi_low}, 0);
    check({tag, "_ctl"}, {load, pi_end, busy, done, mem_rd, len_err, timeout_err}, 0);
    check({tag, "_cnt"}, {word_cnt, mem_addr}, 0);
  endtask
  task automatic set_word(input int k, input logic [15:0] p, input logic [15:0] s, input int d, input int n);
    pat_mem[k] = p;
    sti_mem[k] = s;
    dly[k]     = d;
    blen[k]    = n;
  endtask
  task automatic rand_cfg();
    int n, r;
    logic [15:0] s;
    for (int k = 0; k < NW; k++) begin
      s = 16'($urandom);
      n = 8 * (int'(s[13:12]) + 1);
      r = $urandom_range(0, 99);
      if (r < 10) n = $urandom_range(0, 1) ? n + 1 : n - 1;
      else if (r < 13) n = TMO + $urandom_range(0, 4);
      else if (r < 15) n = TMO - 1;
      r = $urandom_range(0, 99);
      set_word(k, 16'($urandom), s, r < 4 ? 0 : r < 8 ? TMO : $urandom_range(1, 12), n);
    end
  endtask
  task automatic run_case(input bit extra_start, input bit idle_glitch, input int abort_at);
    int exp_nl, exp_lat, nl, t, t_load, t_done, kl;
    bit exp_le, exp_to, to_wait, saw_load, e;
    logic [15:0] s;
    exp_nl = 0; exp_le = 0; exp_to = 0; to_wait = 0;
    for (int k = 0; k < NW; k++) begin
      exp_nl = k + 1;
      if (dly[k] == 0 || dly[k] > TMO) begin exp_to = 1; to_wait = 1; break; end
      if (blen[k] >= TMO) begin exp_to = 1; break; end
      if (blen[k] != 8 * (int'(sti_mem[k][13:12]) + 1)) exp_le = 1;
    end
    kl = exp_nl - 1;
    exp_lat = to_wait ? TMO + 1 : exp_to ? dly[kl] + TMO : dly[kl] + blen[kl] + 1;
    if (idle_glitch) begin
      saw_load = 0;
      sv_extra = 1;
      repeat (3) begin @(negedge clk); saw_load |= load; end
      sv_extra = 0;
      @(negedge clk);
      saw_load |= load;
      check("idle_load", saw_load, 0);
      check("idle_state", {busy, word_cnt, len_err, timeout_err, pi_end}, {1'b0, prev_wc, prev_flags});
    end
    base = resp_cnt;
    start = 1;
    @(negedge clk);
    start = 0;
    check("start_clr", {busy, mem_rd, len_err, timeout_err, pi_end}, 5'b11000);
    nl = 0; t = 0; t_load = 0; t_done = -1;
    while (t < LIMIT) begin
      if (mem_rd) check("fetch_addr", mem_addr, nl);
      if (load) begin
        s = sti_mem[nl];
        e = nl == NW - 1;
        check("pi_data", pi_data, pat_mem[nl]);
        check("pi_fields", {pi_length, pi_fill, pi_msb, pi_low, pi_end}, {s[13:12], s[8], s[4], s[0], e});
        nl++;
        t_load = t;
      end
      if (done) begin t_done = t; break; end
      if (abort_at != 0 && nl == abort_at && t == t_load + dly[nl-1] + 3) begin
        #1 rst_n = 0;
        #1 check_reset_outs("abort");
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check_reset_outs("after_abort");
        prev_wc = 0;
        prev_flags = 0;
        return;
      end
      start = extra_start && t == 10 && busy;
      @(negedge clk);
      t++;
    end
    start = 0;
    if (t_done < 0) check("done_seen", done, 1);
    else begin
      check("loads", nl, exp_nl);
      check("flags", {len_err, timeout_err, pi_end}, {exp_le, exp_to, exp_nl == NW});
      check("word_cnt", word_cnt, exp_nl - 1);
      check("done_lat", t_done - t_load, exp_lat);
      check("done_busy", busy, 0);
      @(negedge clk);
      check("done_pulse", {done, busy}, 0);
    end
    prev_wc = AW'(exp_nl - 1);
    prev_flags = {exp_le, exp_to, exp_nl == NW};
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    rst_n = 1;
    @(negedge clk);
    prev_wc = 0;
    prev_flags = 0;
    set_word(0, 16'h1111, 16'h0000, 2, 8);
    set_word(1, 16'h2222, 16'h1000, 1, 16);
    set_word(2, 16'h3333, 16'h3000, 5, 32);
    set_word(3, 16'hA5C3, 16'h2111, 3, 24);
    set_word(4, 16'h0F0F, 16'h0000, 1, 8);
    set_word(5, 16'hBEEF, 16'h1000, 4, 16);
    run_case(0, 0, 0);
    blen[1] = 15;
    run_case(1, 1, 0);
    blen[1] = 16;
    run_case(0, 1, 0);
    dly[2] = 0;
    run_case(0, 0, 0);
    dly[2] = TMO;
    blen[4] = TMO + 2;
    run_case(0, 0, 0);
    dly[2] = 5;
    blen[4] = 8;
    run_case(0, 0, 5);
    run_case(0, 1, 0);
    repeat (8) begin
      rand_cfg();
      run_case(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
